openflow_wildcard_match_encoder: RTL and testbench



---
 rtl/openflow_wildcard_match_encoder.sv | 81 ++++++++
 tb/tb_openflow_wildcard_match_encoder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/openflow_wildcard_match_encoder.sv
// openflow_wildcard_match_encoder: tracks TCAM lookups through compare latency, priority-encodes the match vector into a credit-throttled FWFT result FIFO and keeps hit/miss counts
module openflow_wildcard_match_encoder #(
  parameter int OPENFLOW_WILDCARD_TABLE_SIZE = 32,
  parameter int LUT_DEPTH_BITS = 5,
  parameter int CAM_LATENCY = 2,
  parameter int RESULT_FIFO_DEPTH = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    lookup_req,
  output logic                                    lookup_ready,
  input  logic                                    cam_busy,
  input  logic [OPENFLOW_WILDCARD_TABLE_SIZE-1:0] cam_match_addr,
  output logic                                    result_valid,
  input  logic                                    result_ready,
  output logic                                    result_hit,
  output logic [LUT_DEPTH_BITS-1:0]               result_index,
  output logic                                    result_multi,
  input  logic                                    counter_clear,
  output logic [31:0]                             hit_count,
  output logic [31:0]                             miss_count
);
  localparam int PW = $clog2(RESULT_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = LUT_DEPTH_BITS + 2;
  logic [CAM_LATENCY-1:0] pipe_q, pipe_d;
  logic [CW-1:0] inflight_q, inflight_d, occ_q, occ_d;
  logic [CW:0] used;
  logic [PW-1:0] wptr_q, rptr_q;
  logic [EW-1:0] mem_q [RESULT_FIFO_DEPTH];
  logic [EW-1:0] head;
  logic [31:0] hit_q, miss_q;
  logic accept, push, pop, enc_hit, enc_multi;
  logic [LUT_DEPTH_BITS-1:0] enc_idx;
  always_comb begin
    enc_idx = '0;
    for (int i = OPENFLOW_WILDCARD_TABLE_SIZE - 1; i >= 0; i--)
      if (cam_match_addr[i]) enc_idx = LUT_DEPTH_BITS'(i);
  end
  assign enc_hit = |cam_match_addr;
  assign enc_multi = |(cam_match_addr & (cam_match_addr - OPENFLOW_WILDCARD_TABLE_SIZE'(1)));
  assign used = {1'b0, inflight_q} + {1'b0, occ_q};
  assign lookup_ready = !cam_busy && (used < (CW + 1)'(RESULT_FIFO_DEPTH));
  assign accept = lookup_req && lookup_ready;
  assign push = pipe_q[CAM_LATENCY-1];
  assign pop = result_valid && result_ready;
  assign pipe_d = CAM_LATENCY'({pipe_q, accept});
  assign inflight_d = inflight_q + CW'(accept) - CW'(push);
  assign occ_d = occ_q + CW'(push) - CW'(pop);
  assign head = mem_q[rptr_q];
  assign result_valid = occ_q != '0;
  assign result_hit = result_valid & head[0];
  assign result_index = result_valid ? head[EW-2:1] : '0;
  assign result_multi = result_valid & head[EW-1];
  assign hit_count = hit_q;
  assign miss_count = miss_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_q <= '0;
      inflight_q <= '0;
      occ_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      hit_q <= '0;
      miss_q <= '0;
    end else begin
      pipe_q <= pipe_d;
      inflight_q <= inflight_d;
      occ_q <= occ_d;
      if (push) begin
        mem_q[wptr_q] <= {enc_multi, enc_idx, enc_hit};
        wptr_q <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
      hit_q <= counter_clear ? '0 : hit_q + 32'(push & enc_hit);
      miss_q <= counter_clear ? '0 : miss_q + 32'(push & ~enc_hit);
    end
  end
  assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && occ_q == CW'(RESULT_FIFO_DEPTH)));
endmodule

// File: tb/tb_openflow_wildcard_match_encoder.sv
// tb_openflow_wildcard_match_encoder: directed plus random stimulus checked against a queue-based reference model
module tb_openflow_wildcard_match_encoder;
  localparam int L = 2;
  localparam int D = 4;
  logic clk = 0, reset = 1, lookup_req = 0, cam_busy = 0, result_ready = 0, counter_clear = 0;
  logic [31:0] cam_match_addr = 0;
  logic lookup_ready, result_valid, result_hit, result_multi;
  logic [4:0] result_index;
  logic [31:0] hit_count, miss_count;
  typedef struct packed {logic hit; logic [4:0] idx; logic multi;} res_t;
  res_t exp_q[$];
  int issue_q[$];
  int cyc = 0, passed = 0, total = 0, fails = 0;
  logic [31:0] hit_m = 0, miss_m = 0;
  openflow_wildcard_match_encoder dut (
    .clk(clk), .reset(reset), .lookup_req(lookup_req), .lookup_ready(lookup_ready),
    .cam_busy(cam_busy), .cam_match_addr(cam_match_addr), .result_valid(result_valid),
    .result_ready(result_ready), .result_hit(result_hit), .result_index(result_index),
    .result_multi(result_multi), .counter_clear(counter_clear), .hit_count(hit_count),
    .miss_count(miss_count)
  );
  always #5 clk = ~clk;
  function automatic res_t ref_enc(input logic [31:0] v);
    res_t r;
    logic [31:0] low;
    low = v & (~v + 32'd1);
    r.hit = v != 0;
    r.idx = r.hit ? 5'($countones(low - 32'd1)) : 5'd0;
    r.multi = $countones(v) > 1;
    return r;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic req, input logic rr, input logic busy, input logic clr,
                      input logic [31:0] vec, input logic frc = 0);
    logic due, ready_m;
    res_t r;
    due = issue_q.size() > 0 && issue_q[0] + L == cyc;
    lookup_req = req;
    result_ready = rr;
    cam_busy = busy;
    counter_clear = clr;
    cam_match_addr = due ? vec : $urandom;
    if (frc) begin
      force dut.hit_q = 32'hFFFF_FFFF;
      #1 release dut.hit_q;
      hit_m = 32'hFFFF_FFFF;
    end
    @(negedge clk);
    ready_m = !busy && (issue_q.size() + exp_q.size() < D);
    chk("lookup_ready", 32'(lookup_ready), 32'(ready_m));
    chk("result_valid", 32'(result_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      chk("result_hit", 32'(result_hit), 32'(exp_q[0].hit));
      chk("result_index", 32'(result_index), 32'(exp_q[0].idx));
      chk("result_multi", 32'(result_multi), 32'(exp_q[0].multi));
    end
    chk("hit_count", hit_count, hit_m);
    chk("miss_count", miss_count, miss_m);
    if (rr && exp_q.size() > 0) void'(exp_q.pop_front());
    if (due) begin
      r = ref_enc(vec);
      exp_q.push_back(r);
      void'(issue_q.pop_front());
      if (r.hit) hit_m++;
      else miss_m++;
    end
    if (clr) begin
      hit_m = 0;
      miss_m = 0;
    end
    if (ready_m && req) issue_q.push_back(cyc);
    cyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1;
    lookup_req = 0;
    result_ready = 0;
    cam_busy = 0;
    counter_clear = 0;
    @(posedge clk);
    #1 reset = 0;
    issue_q.delete();
    exp_q.delete();
    hit_m = 0;
    miss_m = 0;
    @(negedge clk);
    chk("rst_valid", 32'(result_valid), 0);
    chk("rst_hit", 32'(result_hit), 0);
    chk("rst_index", 32'(result_index), 0);
    chk("rst_multi", 32'(result_multi), 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_miss_count", miss_count, 0);
    chk("rst_ready", 32'(lookup_ready), 1);
    cyc++;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [31:0] v;
    @(posedge clk);
    do_reset();
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 32'h0000_0010);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 32'h8000_0006);
    step(0, 1, 0, 0, 32'h0000_0000);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, $urandom);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, $urandom);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, $urandom);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 32'h0000_0100);
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 32'h0001_0000);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 32'h0000_0004, 1);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 32'h0000_0001, 1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 32'h0000_0020);
    step(1, 0, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, $urandom);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: v = 0;
        1: v = 32'd1 << $urandom_range(0, 31);
        2: v = $urandom & $urandom & $urandom;
        default: v = $urandom;
      endcase
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
           $urandom_range(0, 31) == 0, v);
    end
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, $urandom);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
